// File: rtl/fpww_pkg.sv
// fpww_pkg -- shared watch types and limits.
//   bcd_t    : one BCD digit (0..9)
//   SEC_MAX  : last seconds value (59)
//   MIN_MAX  : last minutes value (59)
//   HR24_MAX : last hour in 24-hour mode (23)
//   HR12_MAX : last hour in 12-hour mode (12)
//   toBcd    : converts a 0..99 constant into a {tens, units} BCD pair
package fpww_pkg;
   typedef logic [3:0] bcd_t;

   localparam int SEC_MAX  = 59;
   localparam int MIN_MAX  = 59;
   localparam int HR24_MAX = 23;
   localparam int HR12_MAX = 12;

   function automatic logic [7:0] toBcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction
endpackage

// File: rtl/time_keeper_if.sv
// time_keeper_if -- control and display bundle of the watch time keeper.
//   set_mode, inc_min, inc_hr : controls (driven by the master side)
//   t0..t3                    : BCD min units, min tens, hr units, hr tens
//   secs                      : binary seconds 0..59
//   sec_pulse, min_pulse      : one-cycle strobes
//   pm                        : PM flag (0 in 24-hour builds)
// Modports: master = control/display side, slave = time_keeper.
interface time_keeper_if;
   import fpww_pkg::*;

   logic       set_mode;
   logic       inc_min;
   logic       inc_hr;
   bcd_t       t0, t1, t2, t3;
   logic [5:0] secs;
   logic       sec_pulse;
   logic       min_pulse;
   logic       pm;

   modport master (output set_mode, inc_min, inc_hr,
                   input  t0, t1, t2, t3, secs, sec_pulse, min_pulse, pm);
   modport slave  (input  set_mode, inc_min, inc_hr,
                   output t0, t1, t2, t3, secs, sec_pulse, min_pulse, pm);
endinterface

// File: rtl/bcd_pair_counter.sv
// bcd_pair_counter -- two-digit BCD counter with programmable wrap.
//   uclock, nreset : clock, async active-low reset (loads RST_HI/RST_LO)
//   inc            : advance by one this cycle
//   maxHi/maxLo    : last value before wrapping
//   minHi/minLo    : value loaded on wrap
//   hi/lo          : registered count
//   carry          : combinational, inc while at max (wraps this edge)
module bcd_pair_counter
   import fpww_pkg::*;
#(
   parameter bcd_t RST_HI = 4'd0,
   parameter bcd_t RST_LO = 4'd0
) (
   input  logic uclock,
   input  logic nreset,
   input  logic inc,
   input  bcd_t maxHi,
   input  bcd_t maxLo,
   input  bcd_t minHi,
   input  bcd_t minLo,
   output bcd_t hi,
   output bcd_t lo,
   output logic carry
);
   logic atMax;

   assign atMax = (hi == maxHi) && (lo == maxLo);
   assign carry = inc && atMax;

   always_ff @(posedge uclock or negedge nreset) begin
      if (!nreset) begin
         hi <= RST_HI;
         lo <= RST_LO;
      end else if (inc) begin
         if (atMax) begin
            hi <= minHi;
            lo <= minLo;
         end else if (lo == 4'd9) begin
            hi <= hi + 4'd1;
            lo <= 4'd0;
         end else begin
            lo <= lo + 4'd1;
         end
      end
   end
endmodule

// File: rtl/time_keeper.sv
// time_keeper -- HH:MM:SS watch core with set mode.
//   TICK_DIV : uclock cycles per second
//   uclock   : clock, all state on rising edge
//   nreset   : async active-low reset
//   bus      : time_keeper_if.slave (controls in, BCD digits/secs/strobes out)
// Optional feature: define TWELVE_HOUR_EN for 12/01..11 hours with pm flag;
// otherwise 24-hour only and pm is tied to 0.
module time_keeper
   import fpww_pkg::*;
#(
   parameter int TICK_DIV = 1000
) (
   input  logic          uclock,
   input  logic          nreset,
   time_keeper_if.slave  bus
);
   localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [7:0]    MIN_MAXB   = toBcd(MIN_MAX);
`ifdef TWELVE_HOUR_EN
   localparam logic [7:0]    HR_MAXB    = toBcd(HR12_MAX);
   localparam logic [7:0]    HR_MINB    = 8'h01;
   localparam logic [7:0]    HR_RSTB    = 8'h12;
`else
   localparam logic [7:0]    HR_MAXB    = toBcd(HR24_MAX);
   localparam logic [7:0]    HR_MINB    = 8'h00;
   localparam logic [7:0]    HR_RSTB    = 8'h00;
`endif

   logic [PW-1:0] presc;
   logic [5:0]    secsQ;
   logic          secPulse, minPulse;
   logic [1:0]    minSync, hrSync;
   logic          minPrev, hrPrev;
   logic          setMode, tick, secWrap;
   logic          minEdge, hrEdge, minInc, hrInc, minCarry, hrCarry;
   bcd_t          minHi, minLo, hrHi, hrLo;

   assign setMode = bus.set_mode;
   assign tick    = !setMode && (presc == PRESC_LAST);
   assign secWrap = tick && (secsQ == 6'(SEC_MAX));
   // Edge detect sits behind the 2-flop synchroniser, so a press acts
   // three edges after the raw button rises.
   assign minEdge = minSync[1] && !minPrev;
   assign hrEdge  = hrSync[1]  && !hrPrev;
   assign minInc  = secWrap || (setMode && minEdge);
   // Minute wrap only carries into hours in run mode.
   assign hrInc   = (!setMode && minCarry) || (setMode && hrEdge);

   always_ff @(posedge uclock or negedge nreset) begin
      if (!nreset) begin
         minSync <= 2'b00;
         hrSync  <= 2'b00;
         minPrev <= 1'b0;
         hrPrev  <= 1'b0;
      end else begin
         minSync <= {minSync[0], bus.inc_min};
         hrSync  <= {hrSync[0],  bus.inc_hr};
         minPrev <= minSync[1];
         hrPrev  <= hrSync[1];
      end
   end

   // Set mode parks prescaler and seconds at 0, so leaving it restarts a
   // full second.
   always_ff @(posedge uclock or negedge nreset) begin
      if (!nreset) begin
         presc    <= '0;
         secsQ    <= 6'd0;
         secPulse <= 1'b0;
         minPulse <= 1'b0;
      end else begin
         secPulse <= tick;
         minPulse <= !setMode && minCarry;
         if (setMode || presc == PRESC_LAST) presc <= '0;
         else                                presc <= presc + 1'b1;
         if (setMode || secWrap) secsQ <= 6'd0;
         else if (tick)          secsQ <= secsQ + 6'd1;
      end
   end

   bcd_pair_counter #(.RST_HI(4'd0), .RST_LO(4'd0)) uMin (
      .uclock (uclock),
      .nreset (nreset),
      .inc    (minInc),
      .maxHi  (MIN_MAXB[7:4]),
      .maxLo  (MIN_MAXB[3:0]),
      .minHi  (4'd0),
      .minLo  (4'd0),
      .hi     (minHi),
      .lo     (minLo),
      .carry  (minCarry)
   );

   bcd_pair_counter #(.RST_HI(HR_RSTB[7:4]), .RST_LO(HR_RSTB[3:0])) uHr (
      .uclock (uclock),
      .nreset (nreset),
      .inc    (hrInc),
      .maxHi  (HR_MAXB[7:4]),
      .maxLo  (HR_MAXB[3:0]),
      .minHi  (HR_MINB[7:4]),
      .minLo  (HR_MINB[3:0]),
      .hi     (hrHi),
      .lo     (hrLo),
      .carry  (hrCarry)
   );

`ifdef TWELVE_HOUR_EN
   logic pmQ;
   // Any 11 -> 12 step (run rollover or set-mode press) flips AM/PM.
   always_ff @(posedge uclock or negedge nreset) begin
      if (!nreset)                                    pmQ <= 1'b0;
      else if (hrInc && hrHi == 4'd1 && hrLo == 4'd1) pmQ <= ~pmQ;
   end
   assign bus.pm = pmQ;
`else
   assign bus.pm = 1'b0;
`endif

   assign bus.t0        = minLo;
   assign bus.t1        = minHi;
   assign bus.t2        = hrLo;
   assign bus.t3        = hrHi;
   assign bus.secs      = secsQ;
   assign bus.sec_pulse = secPulse;
   assign bus.min_pulse = minPulse;

   // Hour carry-out has no consumer; keep it visibly terminated.
   logic unusedHrCarry;
   assign unusedHrCarry = hrCarry;
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper -- directed bench for time_keeper with TICK_DIV=4.
module tb_time_keeper;
   logic uclock = 1'b0;
   logic nreset;
   logic seenPulse;
   int   nChecks = 0;
   int   nErrors = 0;
   logic [15:0] hhmm;

   time_keeper_if bus ();

   time_keeper #(.TICK_DIV(4)) dut (
      .uclock (uclock),
      .nreset (nreset),
      .bus    (bus)
   );

   always #5 uclock = ~uclock;

   assign hhmm = {bus.t3, bus.t2, bus.t1, bus.t0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge uclock);
   endtask

   // Hold the raw button(s) long enough to pass the synchroniser, then
   // release; records any strobe seen along the way.
   task automatic press(input logic m, input logic h);
      bus.inc_min = m;
      bus.inc_hr  = h;
      repeat (3) begin
         @(negedge uclock);
         seenPulse = seenPulse | bus.sec_pulse | bus.min_pulse;
      end
      bus.inc_min = 1'b0;
      bus.inc_hr  = 1'b0;
      repeat (3) begin
         @(negedge uclock);
         seenPulse = seenPulse | bus.sec_pulse | bus.min_pulse;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      nreset       = 1'b0;
      bus.set_mode = 1'b0;
      bus.inc_min  = 1'b0;
      bus.inc_hr   = 1'b0;
      seenPulse    = 1'b0;
      #2;
`ifdef TWELVE_HOUR_EN
      chk("rst_time", 32'(hhmm), 'h1200);
`else
      chk("rst_time", 32'(hhmm), 'h0000);
`endif
      chk("rst_secs",   32'(bus.secs), 0);
      chk("rst_pulses", 32'({bus.sec_pulse, bus.min_pulse, bus.pm}), 0);

      // First second after reset release: 4 edges to the strobe.
      cyc(2);
      nreset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("no_early_tick", 32'(bus.sec_pulse), 0);
      end
      cyc(1);
      chk("tick_pulse", 32'(bus.sec_pulse), 1);
      chk("tick_secs",  32'(bus.secs), 1);
      cyc(1);
      chk("tick_width", 32'(bus.sec_pulse), 0);
      chk("tick_hold",  32'(bus.secs), 1);

      bus.set_mode = 1'b1;
      cyc(1);
      chk("set_hold_secs", 32'(bus.secs), 0);
      seenPulse = 1'b0;

`ifdef TWELVE_HOUR_EN
      repeat (11) press(1'b0, 1'b1);
      repeat (59) press(1'b1, 1'b0);
      chk("set_1159",    32'(hhmm), 'h1159);
      chk("set_1159_pm", 32'(bus.pm), 0);
      bus.set_mode = 1'b0;
      cyc(236);
      chk("pre_noon_secs", 32'(bus.secs), 59);
      cyc(4);
      chk("noon_time", 32'(hhmm), 'h1200);
      chk("noon_pm",   32'(bus.pm), 1);
      chk("noon_secs", 32'(bus.secs), 0);
      bus.set_mode = 1'b1;
      cyc(1);
      repeat (11) press(1'b0, 1'b1);
      chk("set_11_time", 32'(hhmm), 'h1100);
      chk("set_11_pm",   32'(bus.pm), 1);
      press(1'b0, 1'b1);
      chk("set_12_time", 32'(hhmm), 'h1200);
      chk("set_12_pm",   32'(bus.pm), 0);
`else
      // Preload 23:59 through set mode, then run up to :59 and roll.
      repeat (23) press(1'b1, 1'b1);
      repeat (36) press(1'b1, 1'b0);
      chk("preload_time",  32'(hhmm), 'h2359);
      chk("set_no_pulse",  32'(seenPulse), 0);
      bus.set_mode = 1'b0;
      cyc(236);
      chk("pre_roll_secs", 32'(bus.secs), 59);
      chk("pre_roll_time", 32'(hhmm), 'h2359);
      chk("pre_roll_minp", 32'(bus.min_pulse), 0);
      cyc(4);
      chk("roll_time", 32'(hhmm), 'h0000);
      chk("roll_secs", 32'(bus.secs), 0);
      chk("roll_minp", 32'(bus.min_pulse), 1);
      chk("roll_secp", 32'(bus.sec_pulse), 1);
      cyc(1);
      chk("minp_width", 32'(bus.min_pulse), 0);

      // Buttons are ignored in run mode.
      press(1'b1, 1'b1);
      chk("ignore_run", 32'(hhmm), 'h0000);

      // Minute wrap in set mode does not carry into hours.
      bus.set_mode = 1'b1;
      cyc(1);
      repeat (59) press(1'b1, 1'b0);
      chk("set_0059", 32'(hhmm), 'h0059);
      seenPulse = 1'b0;
      press(1'b1, 1'b0);
      chk("min_wrap_no_carry", 32'(hhmm), 'h0000);
      chk("min_wrap_no_pulse", 32'(seenPulse), 0);

      // Coincident minute and hour edges both apply; hour wraps 23 -> 00.
      repeat (10) press(1'b1, 1'b1);
      repeat (13) press(1'b0, 1'b1);
      chk("set_2310", 32'(hhmm), 'h2310);
      press(1'b1, 1'b1);
      chk("both_steps", 32'(hhmm), 'h0011);

      // Mid-second async reset at 12:34.
      repeat (12) press(1'b0, 1'b1);
      repeat (23) press(1'b1, 1'b0);
      chk("set_1234", 32'(hhmm), 'h1234);
      bus.set_mode = 1'b0;
      cyc(14);
      chk("mid_secs", 32'(bus.secs), 3);
      #1 nreset = 1'b0;
      #1;
      chk("async_rst_time",   32'(hhmm), 'h0000);
      chk("async_rst_secs",   32'(bus.secs), 0);
      chk("async_rst_pulses", 32'({bus.sec_pulse, bus.min_pulse, bus.pm}), 0);
      #1 nreset = 1'b1;
      cyc(3);
      chk("discard_secs",  32'(bus.secs), 0);
      chk("discard_pulse", 32'(bus.sec_pulse), 0);
      cyc(1);
      chk("restart_pulse", 32'(bus.sec_pulse), 1);
      chk("restart_secs",  32'(bus.secs), 1);
`endif

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end
endmodule
